hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Pipeline hazard controller that drives the datapath's hazard-control inputs. It produces the EX-stage forwarding selects, the per-stage load enables and the ID/EX bubble select, and it flushes IF/ID on taken control transfers. A small state machine sequences load-use stalls, branch-operand stalls and redirect flushes. A saturating counter records lost cycles.

Parameters:
OP_BEQ, 6'd5, opcode of branch-if-equal
OP_J, 6'd6, opcode of jump
OP_JR, 6'd7, opcode of jump-register
OP_JAL, 6'd8, opcode of jump-and-link
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
if_id_inst  in  32  instruction in IF/ID; [31:26] opcode, [25:21] rs, [20:16] rt
branch_eq  in  1  ID-stage register compare result (rs==rt)
id_ex_rs  in  5  rs of the instruction in EX
id_ex_rt  in  5  rt of the instruction in EX
id_ex_wr  in  5  destination register chosen in EX
id_ex_regwrite  in  1  instruction in EX writes the register file
id_ex_memread  in  1  instruction in EX is a load
ex_mem_rd  in  5  destination register in MEM
regwrite_mem  in  1  instruction in MEM writes the register file
mem_wb_rd  in  5  destination register in WB
regwrite_wb  in  1  instruction in WB writes the register file
fwd_a_sel  out  2  ALU operand A select: 00 ID/EX, 01 WB result, 10 EX/MEM result
fwd_b_sel  out  2  ALU operand B select, same encoding
loads  out  5  {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb}; 1 = register loads
bubble_n  out  1  1 = pass decoded control into ID/EX; 0 = insert all-zero control
flush_if  out  1  1 = clear IF/ID on the next edge
stall_count  out  CNT_W  saturating count of non-RUN and stalled cycles

Behaviour:
- Forwarding is combinational and evaluated per operand (X = id_ex_rs for A, id_ex_rt for B).
  - Select 10 if regwrite_mem and ex_mem_rd != 0 and ex_mem_rd == X.
  - Otherwise select 01 if regwrite_wb and mem_wb_rd != 0 and mem_wb_rd == X.
  - Otherwise select 00.
  - MEM always has priority over WB.
- Hazard terms (combinational, from IF/ID fields):
  - lu (load-use) = id_ex_memread and id_ex_rt != 0 and (id_ex_rt == rs or id_ex_rt == rt).
  - bu (branch operand) = opcode == OP_BEQ and id_ex_regwrite and id_ex_wr != 0 and (id_ex_wr == rs or id_ex_wr == rt).
  - redir = opcode in {OP_J, OP_JR, OP_JAL}, or (opcode == OP_BEQ and branch_eq and not bu).
- FSM states: RUN, STALL, FLUSH. State register is reset to RUN asynchronously.
- RUN:
  - If lu or bu: loads = 5'b00111, bubble_n = 0, flush_if = 0; next state STALL. PC and IF/ID hold, and a bubble enters EX.
  - Else if redir: loads = 5'b11111, bubble_n = 1, flush_if = 1; next state FLUSH.
  - Else: loads = 5'b11111, bubble_n = 1, flush_if = 0; stay in RUN.
  - Stall has priority over redirect, so a dependent branch is resolved only after its operand is ready.
- STALL, exactly one cycle:
  - loads = 5'b11111, bubble_n = 1, flush_if = 0; lu, bu and redir are ignored.
  - Next state RUN, where the held instruction is re-evaluated.
  - A back-to-back hazard (e.g. bu still true with a load now in MEM) re-enters STALL from RUN on the following cycle.
- FLUSH, exactly one cycle:
  - loads = 5'b11111, bubble_n = 0 (the squashed IF/ID slot enters EX as a no-op), flush_if = 0.
  - Hazard terms are ignored; next state RUN.
- stall_count:
  - Increments on each rising edge where state != RUN or (state == RUN and (lu or bu)).
  - Saturates at all-ones; it never wraps.
- Reset (rst = 0, any time, including mid-STALL or mid-FLUSH):
  - State goes to RUN immediately; stall_count = 0.
  - Outputs forced to loads = 5'b11111, bubble_n = 1, flush_if = 0, fwd_a_sel = fwd_b_sel = 00.
  - After rst rises, the first edge behaves as RUN.
- Register $0 is never a forwarding or hazard source.
- All outputs except stall_count are functions of the current state and current inputs. There is no added latency.

Test Plan:
- EX/MEM vs MEM/WB priority: ex_mem_rd = 5, regwrite_mem = 1, mem_wb_rd = 5, regwrite_wb = 1, id_ex_rs = 5, id_ex_rt = 0 -> fwd_a_sel = 10, fwd_b_sel = 00. Then regwrite_mem = 0 -> fwd_a_sel = 01.
- Load-use: id_ex_memread = 1, id_ex_rt = 8, if_id_inst rs = 8 -> cycle 0: loads = 00111, bubble_n = 0. Cycle 1: STALL, loads = 11111. Cycle 2: RUN. stall_count = 2.
- Taken BEQ (opcode 5, branch_eq = 1, no bu) -> flush_if = 1 for one cycle, then FLUSH with bubble_n = 0 for one cycle, then RUN. Not-taken BEQ -> no flush.
- BEQ with operand produced in EX (id_ex_wr = rs, id_ex_regwrite = 1) and branch_eq = 1 -> stall first, flush_if = 0. Once bu clears in RUN -> flush_if = 1.
- JR with simultaneous lu -> stall wins; flush_if asserts only on the cycle after STALL returns to RUN.
- rst = 0 mid-STALL -> outputs immediately go to reset values and stall_count = 0. With CNT_W = 2, a continuous stall pattern holds stall_count at 3.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
// master = datapath side (supplies stage fields), slave = hazard unit.
interface hazard_ctrl_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_id_inst;
  logic             branch_eq;
  logic [4:0]       id_ex_rs;
  logic [4:0]       id_ex_rt;
  logic [4:0]       id_ex_wr;
  logic             id_ex_regwrite;
  logic             id_ex_memread;
  logic [4:0]       ex_mem_rd;
  logic             regwrite_mem;
  logic [4:0]       mem_wb_rd;
  logic             regwrite_wb;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [4:0]       loads;
  logic             bubble_n;
  logic             flush_if;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_id_inst, branch_eq, id_ex_rs, id_ex_rt, id_ex_wr,
           id_ex_regwrite, id_ex_memread, ex_mem_rd, regwrite_mem,
           mem_wb_rd, regwrite_wb,
    input  fwd_a_sel, fwd_b_sel, loads, bubble_n, flush_if, stall_count
  );

  modport slave (
    input  if_id_inst, branch_eq, id_ex_rs, id_ex_rt, id_ex_wr,
           id_ex_regwrite, id_ex_memread, ex_mem_rd, regwrite_mem,
           mem_wb_rd, regwrite_wb,
    output fwd_a_sel, fwd_b_sel, loads, bubble_n, flush_if, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding selects, stage load enables,
// ID/EX bubble select and IF/ID flush, sequenced by a RUN/STALL/FLUSH FSM,
// plus a saturating lost-cycle counter.
module hazard_ctrl_unit #(
  parameter logic [5:0]  OP_BEQ = 6'd5,
  parameter logic [5:0]  OP_J   = 6'd6,
  parameter logic [5:0]  OP_JR  = 6'd7,
  parameter logic [5:0]  OP_JAL = 6'd8,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_ctrl_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       lu, bu, redir, is_beq;

  assign opcode = bus.if_id_inst[31:26];
  assign rs     = bus.if_id_inst[25:21];
  assign rt     = bus.if_id_inst[20:16];
  assign is_beq = (opcode == OP_BEQ);

  // Forward select for one EX operand; MEM result outranks WB, $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] x,
    input logic       rw_mem, input logic [4:0] rd_mem,
    input logic       rw_wb,  input logic [4:0] rd_wb
  );
    if (rw_mem && (rd_mem != '0) && (rd_mem == x))   return 2'b10;
    else if (rw_wb && (rd_wb != '0) && (rd_wb == x)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Hazard terms from the instruction held in IF/ID.
  always_comb begin
    lu    = bus.id_ex_memread && (bus.id_ex_rt != '0) &&
            ((bus.id_ex_rt == rs) || (bus.id_ex_rt == rt));
    bu    = is_beq && bus.id_ex_regwrite && (bus.id_ex_wr != '0) &&
            ((bus.id_ex_wr == rs) || (bus.id_ex_wr == rt));
    redir = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL) ||
            (is_beq && bus.branch_eq && !bu);
  end

  // Control outputs and next state; reset forces the idle pass-through values.
  always_comb begin
    state_d       = state_q;
    bus.loads     = '1;
    bus.bubble_n  = 1'b1;
    bus.flush_if  = 1'b0;
    bus.fwd_a_sel = '0;
    bus.fwd_b_sel = '0;
    if (rst) begin
      bus.fwd_a_sel = fwd_sel(bus.id_ex_rs, bus.regwrite_mem, bus.ex_mem_rd,
                              bus.regwrite_wb, bus.mem_wb_rd);
      bus.fwd_b_sel = fwd_sel(bus.id_ex_rt, bus.regwrite_mem, bus.ex_mem_rd,
                              bus.regwrite_wb, bus.mem_wb_rd);
      unique case (state_q)
        RUN: begin
          if (lu || bu) begin
            bus.loads    = 5'b00111;
            bus.bubble_n = 1'b0;
            state_d      = STALL;
          end else if (redir) begin
            bus.flush_if = 1'b1;
            state_d      = FLUSH;
          end
        end
        STALL: state_d = RUN;
        FLUSH: begin
          bus.bubble_n = 1'b0;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Lost-cycle counter: every non-RUN cycle plus RUN cycles that stall.
  always_comb begin
    cnt_d = cnt_q;
    if (((state_q != RUN) || lu || bu) && (cnt_q != '1))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a 16-bit counter instance plus a
// 2-bit counter instance sharing the same inputs for saturation checks.
module tb_hazard_ctrl_unit;

  logic clk;
  logic rst;

  hazard_ctrl_unit_if #(.CNT_W(16)) hif ();
  hazard_ctrl_unit_if #(.CNT_W(2))  hif2 ();

  hazard_ctrl_unit #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(hif.slave));
  hazard_ctrl_unit #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(hif2.slave));

  assign hif2.if_id_inst     = hif.if_id_inst;
  assign hif2.branch_eq      = hif.branch_eq;
  assign hif2.id_ex_rs       = hif.id_ex_rs;
  assign hif2.id_ex_rt       = hif.id_ex_rt;
  assign hif2.id_ex_wr       = hif.id_ex_wr;
  assign hif2.id_ex_regwrite = hif.id_ex_regwrite;
  assign hif2.id_ex_memread  = hif.id_ex_memread;
  assign hif2.ex_mem_rd      = hif.ex_mem_rd;
  assign hif2.regwrite_mem   = hif.regwrite_mem;
  assign hif2.mem_wb_rd      = hif.mem_wb_rd;
  assign hif2.regwrite_wb    = hif.regwrite_wb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  loads;
    logic        bub;
    logic        fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
    return {op, s, t, 16'h0000};
  endfunction

  task automatic clr();
    hif.if_id_inst     = '0;
    hif.branch_eq      = 1'b0;
    hif.id_ex_rs       = '0;
    hif.id_ex_rt       = '0;
    hif.id_ex_wr       = '0;
    hif.id_ex_regwrite = 1'b0;
    hif.id_ex_memread  = 1'b0;
    hif.ex_mem_rd      = '0;
    hif.regwrite_mem   = 1'b0;
    hif.mem_wb_rd      = '0;
    hif.regwrite_wb    = 1'b0;
  endtask

  task automatic set_lu();
    hif.id_ex_memread = 1'b1;
    hif.id_ex_rt      = 5'd8;
    hif.if_id_inst    = mk(6'd0, 5'd8, 5'd3);
  endtask

  task automatic push(input string tag, input logic [4:0] ld, input logic bub, input logic fl,
                      input logic [1:0] fa, input logic [1:0] fb, input int unsigned cnt);
    exp_t e;
    e.tag = tag; e.loads = ld; e.bub = bub; e.fl = fl; e.fa = fa; e.fb = fb; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    int unsigned sat;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      sat = (e.cnt > 3) ? 3 : e.cnt;
      chk({e.tag, ".loads"}, hif.loads,       e.loads);
      chk({e.tag, ".bub"},   hif.bubble_n,    e.bub);
      chk({e.tag, ".flush"}, hif.flush_if,    e.fl);
      chk({e.tag, ".fwd_a"}, hif.fwd_a_sel,   e.fa);
      chk({e.tag, ".fwd_b"}, hif.fwd_b_sel,   e.fb);
      chk({e.tag, ".cnt"},   hif.stall_count, e.cnt);
      chk({e.tag, ".cnt2"},  hif2.stall_count, sat);
    end
  endtask

  // One cycle: expectation queued with the stimulus, checked at the falling edge.
  task automatic cyc(input string tag, input logic [4:0] ld, input logic bub, input logic fl,
                     input logic [1:0] fa, input logic [1:0] fb, input int unsigned cnt);
    push(tag, ld, bub, fl, fa, fb, cnt);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with hazard and forwarding conditions present: outputs forced.
    rst = 1'b0;
    clr();
    set_lu();
    hif.ex_mem_rd = 5'd5; hif.regwrite_mem = 1'b1; hif.id_ex_rs = 5'd5;
    @(posedge clk); #1;
    cyc("rst", 5'b11111, 1, 0, 2'b00, 2'b00, 0);

    rst = 1'b1;
    clr();
    // Forwarding priority and $0 handling.
    hif.ex_mem_rd = 5'd5; hif.regwrite_mem = 1'b1;
    hif.mem_wb_rd = 5'd5; hif.regwrite_wb  = 1'b1;
    hif.id_ex_rs  = 5'd5; hif.id_ex_rt     = 5'd0;
    cyc("fwd_mem_prio", 5'b11111, 1, 0, 2'b10, 2'b00, 0);
    hif.regwrite_mem = 1'b0;
    cyc("fwd_wb", 5'b11111, 1, 0, 2'b01, 2'b00, 0);
    hif.id_ex_rs = 5'd3; hif.id_ex_rt = 5'd5;
    cyc("fwd_b_wb", 5'b11111, 1, 0, 2'b00, 2'b01, 0);
    hif.ex_mem_rd = 5'd7; hif.regwrite_mem = 1'b1;
    hif.id_ex_rs  = 5'd7; hif.id_ex_rt     = 5'd7;
    cyc("fwd_both_mem", 5'b11111, 1, 0, 2'b10, 2'b10, 0);
    hif.ex_mem_rd = 5'd0; hif.mem_wb_rd = 5'd0;
    hif.id_ex_rs  = 5'd0; hif.id_ex_rt  = 5'd0;
    cyc("fwd_r0", 5'b11111, 1, 0, 2'b00, 2'b00, 0);

    // Load-use: stall, one STALL cycle (hazard ignored), back to RUN.
    clr(); set_lu();
    cyc("lu_run", 5'b00111, 0, 0, 2'b00, 2'b00, 0);
    cyc("lu_stall", 5'b11111, 1, 0, 2'b00, 2'b00, 1);
    clr();
    cyc("lu_back", 5'b11111, 1, 0, 2'b00, 2'b00, 2);

    // Taken BEQ -> flush, FLUSH ignores a load-use, then RUN.
    hif.if_id_inst = mk(6'd5, 5'd1, 5'd2); hif.branch_eq = 1'b1;
    cyc("beq_taken", 5'b11111, 1, 1, 2'b00, 2'b00, 2);
    clr(); set_lu();
    cyc("beq_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 2);
    clr();
    cyc("beq_back", 5'b11111, 1, 0, 2'b00, 2'b00, 3);
    hif.if_id_inst = mk(6'd5, 5'd1, 5'd2); hif.branch_eq = 1'b0;
    cyc("beq_nt", 5'b11111, 1, 0, 2'b00, 2'b00, 3);

    // Jumps.
    clr(); hif.if_id_inst = mk(6'd6, 5'd0, 5'd0);
    cyc("j", 5'b11111, 1, 1, 2'b00, 2'b00, 3);
    clr();
    cyc("j_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 3);
    hif.if_id_inst = mk(6'd8, 5'd0, 5'd0);
    cyc("jal", 5'b11111, 1, 1, 2'b00, 2'b00, 4);
    clr();
    cyc("jal_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 4);
    cyc("jal_back", 5'b11111, 1, 0, 2'b00, 2'b00, 5);

    // BEQ with operand produced in EX: stall twice back-to-back, then redirect.
    hif.if_id_inst = mk(6'd5, 5'd4, 5'd2); hif.branch_eq = 1'b1;
    hif.id_ex_regwrite = 1'b1; hif.id_ex_wr = 5'd4;
    cyc("bu_run", 5'b00111, 0, 0, 2'b00, 2'b00, 5);
    cyc("bu_stall", 5'b11111, 1, 0, 2'b00, 2'b00, 6);
    cyc("bu_again", 5'b00111, 0, 0, 2'b00, 2'b00, 7);
    cyc("bu_stall2", 5'b11111, 1, 0, 2'b00, 2'b00, 8);
    hif.id_ex_regwrite = 1'b0;
    cyc("bu_resolve", 5'b11111, 1, 1, 2'b00, 2'b00, 9);
    clr();
    cyc("bu_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 9);
    cyc("bu_back", 5'b11111, 1, 0, 2'b00, 2'b00, 10);

    // JR with simultaneous load-use: stall wins, redirect afterwards.
    hif.if_id_inst = mk(6'd7, 5'd9, 5'd0);
    hif.id_ex_memread = 1'b1; hif.id_ex_rt = 5'd9;
    cyc("jr_lu", 5'b00111, 0, 0, 2'b00, 2'b00, 10);
    hif.id_ex_memread = 1'b0; hif.id_ex_rt = 5'd0;
    cyc("jr_stall", 5'b11111, 1, 0, 2'b00, 2'b00, 11);
    cyc("jr_redir", 5'b11111, 1, 1, 2'b00, 2'b00, 12);
    clr();
    cyc("jr_flush", 5'b11111, 0, 0, 2'b00, 2'b00, 12);
    cyc("jr_back", 5'b11111, 1, 0, 2'b00, 2'b00, 13);

    // Reset asserted in the middle of a STALL cycle.
    set_lu();
    cyc("pre_rst_lu", 5'b00111, 0, 0, 2'b00, 2'b00, 13);
    hif.ex_mem_rd = 5'd5; hif.regwrite_mem = 1'b1; hif.id_ex_rs = 5'd5;
    push("pre_rst_stall", 5'b11111, 1, 0, 2'b10, 2'b00, 14);
    @(negedge clk);
    check_pop();
    #1 rst = 1'b0;
    push("mid_rst", 5'b11111, 1, 0, 2'b00, 2'b00, 0);
    #1 check_pop();
    @(posedge clk); #1;

    // Release with a continuous load-use: first edge acts as RUN, 2-bit counter saturates.
    rst = 1'b1;
    clr(); set_lu();
    cyc("sat0", 5'b00111, 0, 0, 2'b00, 2'b00, 0);
    cyc("sat1", 5'b11111, 1, 0, 2'b00, 2'b00, 1);
    cyc("sat2", 5'b00111, 0, 0, 2'b00, 2'b00, 2);
    cyc("sat3", 5'b11111, 1, 0, 2'b00, 2'b00, 3);
    cyc("sat4", 5'b00111, 0, 0, 2'b00, 2'b00, 4);
    cyc("sat5", 5'b11111, 1, 0, 2'b00, 2'b00, 5);
    cyc("sat6", 5'b00111, 0, 0, 2'b00, 2'b00, 6);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
